regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the 32x32 core register file (write sampled on negedge clk; x0 hardwired to zero).
- Shares that port between three requesters: core writeback (highest priority), the WOS filter accelerator result stream (buffered in a small FIFO), and the host/debug loader.
- Keeps a pending-write scoreboard and raises a hazard stall so the core never reads stale data or reorders writes to the same register.

Parameters:
- DEPTH, 4, accelerator result FIFO entries (power of 2, >=2).
- AW, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wb_en  in  1  core writeback request.
- wb_idx  in  5  core writeback register index.
- wb_data  in  32  core writeback data.
- rd_idx1  in  5  core decode read index 1, used for the hazard check.
- rd_idx2  in  5  core decode read index 2, used for the hazard check.
- acc_valid  in  1  accelerator result valid.
- acc_ready  out  1  FIFO can accept the accelerator result.
- acc_idx  in  5  accelerator destination register index.
- acc_data  in  32  accelerator result data.
- host_req  in  1  host write request; held until ack.
- host_idx  in  5  host destination register index.
- host_data  in  32  host write data.
- host_ack  out  1  one-cycle pulse when the host write is performed.
- wr_en  out  1  to register file.
- wr_idx  out  5  to register file.
- wr_data  out  32  to register file.
- hazard  out  1  core must stall this cycle.
- pending_mask  out  32  registers with a queued accelerator write.

Behaviour:
- Reset (rst=0, async):
  - FIFO empty (head=tail=0, count=0); pending_mask=0; rr_last=HOST, so the FIFO wins the first tie.
  - All outputs combinationally derived from this state: wr_en=0, host_ack=0, acc_ready=1.
  - Reset mid-operation discards queued writes with no partial write.
- Hazard (combinational): hazard = pending_mask[rd_idx1] | pending_mask[rd_idx2] | (wb_en & pending_mask[wb_idx]). Index 0 never counts, because pending_mask[0] is never set.
- Core writeback is eligible when wb_en=1, wb_idx!=0 and pending_mask[wb_idx]=0.
  - An eligible core write always wins, with zero latency: the wr_* outputs are driven combinationally from the wb_* inputs in the same cycle.
  - wb_en with wb_idx=0 is a no-op and does not block others.
  - wb_en to a pending register is suppressed; the core holds it because of hazard.
- Arbitration between FIFO head and host, only when no eligible core write:
  - Only one non-empty -> it wins.
  - Both -> round-robin: grant the one not equal to rr_last.
  - rr_last updates on every FIFO or host grant.
- FIFO grant: wr_*=head entry; on posedge, pop and clear pending_mask[head.idx].
- Host grant: wr_*=host_*, host_ack=1 that cycle. host_idx=0 is still acked, with wr_en=0.
- Host to a pending index: the write is legal and is performed in arbitration order. The host is responsible for ordering; no check.
- Enqueue:
  - acc_ready = (count<DEPTH) & ~pending_mask[acc_idx].
  - One unresolved write per register maximum.
  - acc_valid & acc_ready -> push on posedge and set pending_mask[acc_idx].
  - acc_idx=0 -> accepted (acc_ready=1) and dropped: no push, no mask set.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; mask set and clear both apply. They target different indices by construction.
  - When full, acc_ready=0 even if a pop occurs that cycle. There is no combinational full-bypass.
- Pointers wrap modulo DEPTH; count is AW+1 bits.
- Guaranteed latencies:
  - Accelerator result reaches the register file at least 1 cycle after acceptance.
  - Host waits at most DEPTH+1 non-core cycles once the FIFO is non-empty.

Decomposition:
- Shared package rv_pkg:
  - XLEN=32, REG_IDX_W=5, NUM_REGS=32.
  - Grant encoding localparams GNT_NONE / GNT_CORE / GNT_FIFO / GNT_HOST.
- One sub-module, wr_fifo: sync FIFO of {idx[4:0], data[31:0]} with push/pop/full/empty/count and head output.
- Scoreboard and arbiter stay in the top level.

Test Plan:
- Reset mid-queue: push acc idx 5, assert rst=0 for a cycle -> pending_mask=0, acc_ready=1, no write of x5 afterwards.
- Core priority: wb_en idx 3 = 0x11, FIFO holding idx 7 = 0x22 in the same cycle -> write x3=0x11 first, x7=0x22 next cycle; pending_mask[7] clears after it.
- Hazard: acc push idx 9, and with core stalled (wb_en=0), drive rd_idx1=9 -> hazard=1 until x9 is written, then 0. Then wb_en idx 9 while pending -> suppressed with hazard=1, and x9 ends up holding the core value after the core retries.
- Full and duplicate:
  - Push 4 distinct indices with wb_en held high -> acc_ready=0 on the 5th.
  - acc_idx equal to a pending index -> acc_ready=0.
- Round-robin: FIFO holds 2 entries and host_req is held, with no core writes -> grant order FIFO, HOST, FIFO. host_ack is a single-cycle pulse.
- x0 handling:
  - acc_idx=0 is accepted with no push.
  - wb_idx=0 gives no write.
  - host_idx=0 is acked with wr_en=0.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file types and write-port grant encodings
package rv_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CORE = 2'd1;
  localparam logic [1:0] GNT_FIFO = 2'd2;
  localparam logic [1:0] GNT_HOST = 2'd3;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } wr_entry_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - requester and register-file signals of the write arbiter
interface regfile_wr_arbiter_if;
  import rv_pkg::*;

  logic                 wb_en;
  logic [REG_IDX_W-1:0] wb_idx;
  logic [XLEN-1:0]      wb_data;
  logic [REG_IDX_W-1:0] rd_idx1;
  logic [REG_IDX_W-1:0] rd_idx2;
  logic                 acc_valid;
  logic                 acc_ready;
  logic [REG_IDX_W-1:0] acc_idx;
  logic [XLEN-1:0]      acc_data;
  logic                 host_req;
  logic [REG_IDX_W-1:0] host_idx;
  logic [XLEN-1:0]      host_data;
  logic                 host_ack;
  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]      wr_data;
  logic                 hazard;
  logic [NUM_REGS-1:0]  pending_mask;

  modport slave (
    input  wb_en, wb_idx, wb_data, rd_idx1, rd_idx2,
    input  acc_valid, acc_idx, acc_data,
    input  host_req, host_idx, host_data,
    output acc_ready, host_ack, wr_en, wr_idx, wr_data, hazard, pending_mask
  );

  modport master (
    output wb_en, wb_idx, wb_data, rd_idx1, rd_idx2,
    output acc_valid, acc_idx, acc_data,
    output host_req, host_idx, host_data,
    input  acc_ready, host_ack, wr_en, wr_idx, wr_data, hazard, pending_mask
  );
endinterface

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
// rtl/regfile_wr_arbiter_wr_fifo.sv - accelerator result FIFO of {idx, data} entries
module wr_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count,
  output wr_entry_t head
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [AW-1:0]   head_ptr;
  logic [AW-1:0]   tail_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_entry;
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[head_ptr];
endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - shares the register-file write port between core, accelerator FIFO and host
module regfile_wr_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic                full;
  logic                empty;
  logic [AW:0]         count;
  wr_entry_t           head;
  wr_entry_t           push_entry;
  logic [NUM_REGS-1:0] pending_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [1:0]          grant;
  logic [1:0]          rr_last;
  logic                push;
  logic                pop;
  logic                core_elig;

  assign push_entry = '{idx: bus.acc_idx, data: bus.acc_data};

  wr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .head       (head)
  );

  always_ff @(posedge clk) begin
    if (rst) assert (full == (count == FULL_CNT));
  end

  // One queued write per register keeps FIFO order and register order identical.
  assign bus.acc_ready    = ~full & ~pending_mask[bus.acc_idx];
  assign push             = bus.acc_valid & bus.acc_ready & (bus.acc_idx != '0);
  assign core_elig        = bus.wb_en & (bus.wb_idx != '0) & ~pending_mask[bus.wb_idx];
  assign bus.hazard       = pending_mask[bus.rd_idx1] | pending_mask[bus.rd_idx2]
                          | (bus.wb_en & pending_mask[bus.wb_idx]);
  assign bus.pending_mask = pending_mask;

  always_comb begin
    grant = GNT_NONE;
    if (core_elig)                grant = GNT_CORE;
    else if (!empty && bus.host_req) grant = (rr_last == GNT_HOST) ? GNT_FIFO : GNT_HOST;
    else if (!empty)              grant = GNT_FIFO;
    else if (bus.host_req)        grant = GNT_HOST;
  end

  assign pop          = (grant == GNT_FIFO);
  assign bus.host_ack = (grant == GNT_HOST);

  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_data = '0;
    case (grant)
      GNT_CORE: begin
        bus.wr_en   = 1'b1;
        bus.wr_idx  = bus.wb_idx;
        bus.wr_data = bus.wb_data;
      end
      GNT_FIFO: begin
        bus.wr_en   = 1'b1;
        bus.wr_idx  = head.idx;
        bus.wr_data = head.data;
      end
      GNT_HOST: begin
        bus.wr_en   = (bus.host_idx != '0);
        bus.wr_idx  = bus.host_idx;
        bus.wr_data = bus.host_data;
      end
      default: ;
    endcase
  end

  assign set_mask = push ? (NUM_REGS'(1) << bus.acc_idx) : '0;
  assign clr_mask = pop  ? (NUM_REGS'(1) << head.idx)    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_mask <= '0;
      rr_last      <= GNT_HOST;
    end else begin
      pending_mask <= (pending_mask & ~clr_mask) | set_mask;
      if (grant == GNT_FIFO || grant == GNT_HOST) rr_last <= grant;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.wr_en && bus.wr_idx != 5'd0) rf[bus.wr_idx] <= bus.wr_data;

  task automatic idle();
    bus.wb_en = 1'b0; bus.wb_idx = '0; bus.wb_data = '0;
    bus.rd_idx1 = '0; bus.rd_idx2 = '0;
    bus.acc_valid = 1'b0; bus.acc_idx = '0; bus.acc_data = '0;
    bus.host_req = 1'b0; bus.host_idx = '0; bus.host_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %0b want 0", bus.wr_en); end
    checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL rst_host_ack got %0b want 0", bus.host_ack); end
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL rst_acc_ready got %0b want 1", bus.acc_ready); end
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL rst_mask got %h want 0", bus.pending_mask); end
    cyc(); bus.acc_valid = 1'b1; bus.acc_idx = 5'd5; bus.acc_data = 32'h55;
    @(negedge clk);
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL midq_ready got %0b want 1", bus.acc_ready); end
    cyc(); idle(); rst = 1'b0; #1;
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL midq_mask got %h want 0", bus.pending_mask); end
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL midq_ready_rst got %0b want 1", bus.acc_ready); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL midq_wr_in_rst got %0b want 0", bus.wr_en); end
    cyc(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL midq_no_x5 cycle %0d got wr_en %0b idx %0d want 0", i, bus.wr_en, bus.wr_idx); end
    end
  endtask

  task automatic test_core_priority();
    cyc(); idle(); bus.acc_valid = 1'b1; bus.acc_idx = 5'd7; bus.acc_data = 32'h22;
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL prio_idle got %0b want 0", bus.wr_en); end
    cyc(); idle(); bus.wb_en = 1'b1; bus.wb_idx = 5'd3; bus.wb_data = 32'h11;
    @(negedge clk);
    checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'd3, 32'h11})
      begin errors++; $display("FAIL prio_core got en %0b idx %0d data %h want 1 3 11", bus.wr_en, bus.wr_idx, bus.wr_data); end
    checks++; if (bus.pending_mask !== 32'h80) begin errors++; $display("FAIL prio_mask got %h want 80", bus.pending_mask); end
    cyc(); idle();
    @(negedge clk);
    checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'd7, 32'h22})
      begin errors++; $display("FAIL prio_fifo got en %0b idx %0d data %h want 1 7 22", bus.wr_en, bus.wr_idx, bus.wr_data); end
    cyc();
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL prio_mask_clr got %h want 0", bus.pending_mask); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL prio_after got %0b want 0", bus.wr_en); end
  endtask

  task automatic test_hazard();
    cyc(); idle(); bus.acc_valid = 1'b1; bus.acc_idx = 5'd9; bus.acc_data = 32'h99; bus.rd_idx1 = 5'd9;
    @(negedge clk);
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL haz_before got %0b want 0", bus.hazard); end
    cyc(); bus.acc_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL haz_pending got %0b want 1", bus.hazard); end
    checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'd9, 32'h99})
      begin errors++; $display("FAIL haz_x9 got en %0b idx %0d data %h want 1 9 99", bus.wr_en, bus.wr_idx, bus.wr_data); end
    cyc();
    @(negedge clk);
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL haz_clear got %0b want 0", bus.hazard); end
    cyc(); idle(); bus.acc_valid = 1'b1; bus.acc_idx = 5'd9; bus.acc_data = 32'h77;
    cyc(); idle(); bus.wb_en = 1'b1; bus.wb_idx = 5'd9; bus.wb_data = 32'h1234;
    @(negedge clk);
    checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL haz_wb_pending got %0b want 1", bus.hazard); end
    checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'd9, 32'h77})
      begin errors++; $display("FAIL haz_wb_suppressed got en %0b idx %0d data %h want 1 9 77", bus.wr_en, bus.wr_idx, bus.wr_data); end
    cyc();
    @(negedge clk);
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL haz_retry_hazard got %0b want 0", bus.hazard); end
    checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'd9, 32'h1234})
      begin errors++; $display("FAIL haz_retry got en %0b idx %0d data %h want 1 9 1234", bus.wr_en, bus.wr_idx, bus.wr_data); end
    cyc(); idle();
    checks++; if (rf[9] !== 32'h1234) begin errors++; $display("FAIL haz_x9_final got %h want 1234", rf[9]); end
  endtask

  task automatic test_full_dup();
    cyc(); idle(); bus.wb_en = 1'b1; bus.wb_idx = 5'd1; bus.wb_data = 32'h1;
    bus.acc_valid = 1'b1; bus.acc_idx = 5'd10; bus.acc_data = 32'hA0;
    @(negedge clk);
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL full_push10 got %0b want 1", bus.acc_ready); end
    cyc(); bus.acc_idx = 5'd10; bus.acc_data = 32'hEE;
    @(negedge clk);
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL dup_ready got %0b want 0", bus.acc_ready); end
    for (int i = 11; i <= 13; i++) begin
      cyc(); bus.acc_idx = 5'(i); bus.acc_data = 32'(i) << 4;
      @(negedge clk);
      checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL full_push%0d got %0b want 1", i, bus.acc_ready); end
    end
    cyc(); bus.acc_idx = 5'd14; bus.acc_data = 32'hE0;
    @(negedge clk);
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL full_5th got %0b want 0", bus.acc_ready); end
    checks++; if (bus.pending_mask !== 32'h3C00) begin errors++; $display("FAIL full_mask got %h want 3c00", bus.pending_mask); end
    cyc(); bus.wb_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.acc_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got %0b want 0", bus.acc_ready); end
    checks++; if ({bus.wr_idx, bus.wr_data} !== {5'd10, 32'hA0})
      begin errors++; $display("FAIL drain10 got idx %0d data %h want 10 a0", bus.wr_idx, bus.wr_data); end
    for (int i = 11; i <= 13; i++) begin
      cyc(); bus.acc_valid = 1'b0;
      @(negedge clk);
      checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data} !== {1'b1, 5'(i), 32'(i) << 4})
        begin errors++; $display("FAIL drain%0d got en %0b idx %0d data %h", i, bus.wr_en, bus.wr_idx, bus.wr_data); end
    end
    cyc();
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL drain_mask got %h want 0", bus.pending_mask); end
  endtask

  task automatic test_round_robin();
    cyc(); idle(); rst = 1'b0;
    cyc(); rst = 1'b1;
    bus.wb_en = 1'b1; bus.wb_idx = 5'd1; bus.wb_data = 32'h1;
    bus.acc_valid = 1'b1; bus.acc_idx = 5'd20; bus.acc_data = 32'h2020;
    cyc(); bus.acc_idx = 5'd21; bus.acc_data = 32'h2121;
    cyc(); bus.acc_valid = 1'b0; bus.wb_en = 1'b0;
    bus.host_req = 1'b1; bus.host_idx = 5'd22; bus.host_data = 32'h2222;
    @(negedge clk);
    checks++; if ({bus.wr_idx, bus.wr_data, bus.host_ack} !== {5'd20, 32'h2020, 1'b0})
      begin errors++; $display("FAIL rr_first got idx %0d data %h ack %0b want 20 2020 0", bus.wr_idx, bus.wr_data, bus.host_ack); end
    cyc();
    @(negedge clk);
    checks++; if ({bus.wr_en, bus.wr_idx, bus.wr_data, bus.host_ack} !== {1'b1, 5'd22, 32'h2222, 1'b1})
      begin errors++; $display("FAIL rr_host got en %0b idx %0d data %h ack %0b want 1 22 2222 1", bus.wr_en, bus.wr_idx, bus.wr_data, bus.host_ack); end
    cyc(); bus.host_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.wr_idx, bus.wr_data, bus.host_ack} !== {5'd21, 32'h2121, 1'b0})
      begin errors++; $display("FAIL rr_third got idx %0d data %h ack %0b want 21 2121 0", bus.wr_idx, bus.wr_data, bus.host_ack); end
    cyc();
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rr_done got %0b want 0", bus.wr_en); end
  endtask

  task automatic test_x0();
    cyc(); idle(); bus.acc_valid = 1'b1; bus.acc_idx = 5'd0; bus.acc_data = 32'hDEAD;
    @(negedge clk);
    checks++; if (bus.acc_ready !== 1'b1) begin errors++; $display("FAIL x0_acc_ready got %0b want 1", bus.acc_ready); end
    cyc(); bus.acc_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.pending_mask, bus.wr_en} !== {32'h0, 1'b0})
      begin errors++; $display("FAIL x0_acc_drop got mask %h en %0b want 0 0", bus.pending_mask, bus.wr_en); end
    cyc(); bus.wb_en = 1'b1; bus.wb_idx = 5'd0; bus.wb_data = 32'hBEEF;
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL x0_wb got %0b want 0", bus.wr_en); end
    cyc(); bus.host_req = 1'b1; bus.host_idx = 5'd0; bus.host_data = 32'hCAFE;
    @(negedge clk);
    checks++; if ({bus.host_ack, bus.wr_en} !== {1'b1, 1'b0})
      begin errors++; $display("FAIL x0_host got ack %0b en %0b want 1 0", bus.host_ack, bus.wr_en); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (bus.host_ack !== 1'b0) begin errors++; $display("FAIL x0_host_pulse got %0b want 0", bus.host_ack); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_core_priority();
    test_hazard();
    test_full_dup();
    test_round_robin();
    test_x0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
